// File: rtl/detect_low2high.sv
// Rising-edge detector for a slow or asynchronous line: synchronizer chain, optional
// persistence filter, and a registered one-cycle pulse per accepted low-to-high change.
module detect_low2high #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic signal,
  output logic low2HighSignal
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_q, level_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   pulse_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Flops reset high so an idle (high) line never looks like a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= signal;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync;
      cnt_d   = '0;
      pulse_d = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q        <= 1'b1;
      cnt_q          <= '0;
      low2HighSignal <= 1'b0;
    end else begin
      level_q        <= level_d;
      cnt_q          <= cnt_d;
      low2HighSignal <= pulse_d;
    end
  end

endmodule

// File: tb/tb_detect_low2high.sv
// Scoreboard bench: five differently-parameterised detectors share one random line;
// expected pulses come from a windowed "last N samples disagree" model of accepted level.
module tb_detect_low2high;

  localparam int N = 5;
  localparam int S_CFG [N] = '{2, 2, 1, 4, 3};
  localparam int F_CFG [N] = '{1, 4, 1, 1, 3};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         signal = 1'b1;
  logic [N-1:0] out;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    detect_low2high #(
      .SYNC_STAGES  (S_CFG[g]),
      .FILTER_CYCLES(F_CFG[g])
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .signal        (signal),
      .low2HighSignal(out[g])
    );
  end

  bit           hist[$];   // line value sampled at each clock edge since reset release
  bit           lvl [N];   // accepted level per configuration
  logic [N-1:0] exp_q[$];
  int           tests = 0;
  int           fails = 0;
  bit           started = 0;

  function automatic bit seen(input int idx);
    return (idx < 0) ? 1'b1 : hist[idx];
  endfunction

  // Drive one cycle of stimulus and queue the output expected after the next rising edge.
  task automatic step(input bit sig, input bit rst);
    logic [N-1:0] e;
    int           n;
    bit           flip;
    @(negedge clk);
    signal = sig;
    reset  = rst;
    e      = '0;
    if (rst) begin
      hist.delete();
      for (int c = 0; c < N; c++) lvl[c] = 1'b1;
      #1;
      tests++;
      if (out !== '0) begin
        fails++;
        $display("FAIL async_clear t=%0t out=%b required=%b", $time, out, {N{1'b0}});
      end
    end else begin
      hist.push_back(sig);
      n = hist.size() - 1;
      for (int c = 0; c < N; c++) begin
        flip = 1'b1;
        for (int j = 0; j < F_CFG[c]; j++) begin
          if (seen(n - j - S_CFG[c]) == lvl[c]) flip = 1'b0;
        end
        if (flip) begin
          e[c]   = ~lvl[c];
          lvl[c] = ~lvl[c];
        end
      end
    end
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    logic [N-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (started) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow t=%0t out=%b required=<queued value>", $time, out);
        end
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (out !== e) begin
          fails++;
          $display("FAIL pulse t=%0t out=%b required=%b", $time, out, e);
        end
      end
    end
  end

  initial begin
    int  len;
    bit  v;
    int  cyc;
    // Reset with line high, then release: no edge reported.
    repeat (10) step(1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0);
    // Two clean low periods, each followed by a rise.
    repeat (18) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    // Reset lands between a rise and its pulse; rises while held in reset.
    repeat (18) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    // Short low glitch, then a qualifying low.
    repeat (2) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    // Short high glitch inside a long low, then a steady high.
    repeat (20) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    // Random run lengths straddling every filter depth, with occasional resets.
    cyc = 0;
    v   = 1'b0;
    while (cyc < 3000) begin
      if ($urandom_range(0, 39) == 0) begin
        len = $urandom_range(1, 3);
        repeat (len) step(1'(($urandom() >> 3) & 1), 1'b1);
      end else begin
        len = $urandom_range(1, 8);
        repeat (len) step(v, 1'b0);
        v = ~v;
      end
      cyc += len;
    end
    repeat (10) step(1'b1, 1'b0);
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/detect_low2high.md
# detect_low2high

Synchronous rising-edge (low-to-high) detector for a slow, possibly asynchronous single-bit input such as a serial-port line. The input is brought into the clock domain through a synchronizer chain and optionally glitch-filtered. A one-clock pulse is produced each time the accepted level changes from low to high. It sits at the front of the serial receive path and feeds edge events to downstream control logic.

## Interface
- SYNC_STAGES, default 2: synchronizer flip-flop depth; legal 1..4.
- FILTER_CYCLES, default 1: consecutive sampled cycles a new level must persist before it is accepted; legal 1..65535; 1 means no filtering.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- signal  input  1  monitored line; may be asynchronous to clk.
- low2HighSignal  output  1  registered; high for exactly one clk cycle per accepted low-to-high transition.

## Operation
- Synchronizer: `signal` shifts through SYNC_STAGES flops; the last stage is `sync`.
- Accepted level `level_q` and disagreement counter `cnt` (width clog2(FILTER_CYCLES+1)):
  - if `sync == level_q`: `cnt <= 0`;
  - else if `cnt == FILTER_CYCLES-1`: `level_q <= sync`, `cnt <= 0`;
  - else `cnt <= cnt+1`.
- `low2HighSignal <= (level_q == 0) && (level update to 1 this cycle)`; otherwise 0. It is never asserted on two consecutive cycles.
- High-to-low transitions update `level_q` but produce no output.
- Reset state (asynchronous): all synchronizer flops = 1, `level_q` = 1, `cnt` = 0, `low2HighSignal` = 0. Treating the idle line as high means that, after reset, an edge is reported only after a low has been accepted. A line already high at reset release gives no pulse.
- Glitch rejection: an excursion shorter than FILTER_CYCLES sampled cycles resets `cnt` when `sync` returns to `level_q`. Such an excursion is ignored.
- Reset asserted mid-operation clears any pending count and any in-flight pulse within the same cycle. After reset releases, detection restarts from the reset state.
- No arithmetic overflow: `cnt` never exceeds FILTER_CYCLES-1.

## Timing
- Let edge k be the first rising clk edge that samples `signal`=1 after a stable accepted low.
- `sync` becomes 1 after edge k+SYNC_STAGES-1.
- `low2HighSignal` rises after edge k+SYNC_STAGES+FILTER_CYCLES-1 and falls after the next edge. With defaults this is k+2, and the pulse is 1 cycle wide.
- Falling edges are accepted with the same latency, with no output.
- Minimum detectable low period is FILTER_CYCLES sampled cycles. The same applies to the following high.
- Input must meet no setup requirement. Metastability is handled by the synchronizer only when SYNC_STAGES ≥ 2.
- Output changes only on clk rising edges, or asynchronously to 0 on reset.

## Test plan
- Defaults, 10 ns clk, reset high 0–100 ns, `signal`=1 throughout -> `low2HighSignal` stays 0 (no edge on release).
- Defaults, reset released; `signal` 1→0 at 1000 ns, held 180 ns, then 1, then 0 for 100 ns, then 1 -> exactly two 10 ns pulses, each starting on the 2nd clk edge after the corresponding rise; no pulse on either fall.
- Reset reasserted at 1190 ns, between the first rise and its pulse -> pulse suppressed. While reset is held, the output stays 0 despite later rises.
- FILTER_CYCLES=4: 2-cycle low glitch, then steady high -> no pulse. A 4-cycle low followed by high -> one pulse, SYNC_STAGES+4-1 edges after the rise.
- FILTER_CYCLES=4: 2-cycle high glitch during a long low -> no pulse, `cnt` returns to 0. A later steady high -> exactly one pulse.
- SYNC_STAGES=1 and 4 with FILTER_CYCLES=1: single rise -> pulse latency of 1 and 4 edges respectively, width 1 cycle.
